// File: rtl/wb_seg_q.sv
// In-order retire queue between MEM and the register-file write port.
// Optional lookup of queued-but-unwritten results enabled by `define WB_SEG_FWD_EN.
module wb_seg_q #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel_lmd,
  input  logic              in_wr_en,
  input  logic [REG_AW-1:0] in_wr_addr,
  input  logic [DATA_W-1:0] in_lmd,
  input  logic [DATA_W-1:0] in_aluo,
  input  logic              in_cond,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_write,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              cond,
  output logic [31:0]       retired_cnt,
  input  logic [REG_AW-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [REG_AW-1:0] r_addr [DEPTH];
  logic [DEPTH-1:0]  r_wen;
  logic [DEPTH-1:0]  r_cond;

  logic [CW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [31:0]       r_retired;

  logic              w_push;
  logic              w_pop;
  logic [IW-1:0]     w_wr_idx;
  logic [IW-1:0]     w_rd_idx;
  logic [DATA_W-1:0] w_in_data;

  function automatic logic [CW-1:0] next_ptr(input logic [CW-1:0] p);
    return (p == CW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (r_count != CW'(DEPTH));
  assign wb_valid  = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = wb_valid & wb_ready;
  assign w_wr_idx  = r_wr_ptr[IW-1:0];
  assign w_rd_idx  = r_rd_ptr[IW-1:0];
  // Data mux resolved at push so each slot holds only the value to be written.
  assign w_in_data = in_sel_lmd ? in_lmd : in_aluo;

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_data[w_wr_idx] <= w_in_data;
      r_addr[w_wr_idx] <= in_wr_addr;
      r_wen[w_wr_idx]  <= in_wr_en;
      r_cond[w_wr_idx] <= in_cond;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_retired <= '0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop) begin
        r_rd_ptr  <= next_ptr(r_rd_ptr);
        r_retired <= r_retired + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields are gated so an empty queue never exposes stale storage.
  assign wb_addr     = wb_valid ? r_addr[w_rd_idx] : '0;
  assign wb_data     = wb_valid ? r_data[w_rd_idx] : '0;
  assign cond        = wb_valid ? r_cond[w_rd_idx] : 1'b0;
  assign wb_write    = wb_valid & r_wen[w_rd_idx] & (r_addr[w_rd_idx] != '0);
  assign retired_cnt = r_retired;

`ifdef WB_SEG_FWD_EN
  int w_fwd_idx;

  // Scan oldest to newest so the youngest matching entry is left on the output.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = '0;
    w_fwd_idx = 0;
    for (int k = 0; k < DEPTH; k++) begin
      w_fwd_idx = int'(r_rd_ptr) + k;
      if (w_fwd_idx >= DEPTH) w_fwd_idx = w_fwd_idx - DEPTH;
      if ((k < int'(r_count)) && r_wen[w_fwd_idx[IW-1:0]] &&
          (r_addr[w_fwd_idx[IW-1:0]] != '0) &&
          (r_addr[w_fwd_idx[IW-1:0]] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data[w_fwd_idx[IW-1:0]];
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwd_addr;
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
`endif

endmodule

// File: tb/tb_wb_seg_q.sv
// Self-checking bench for wb_seg_q: queue-based reference model, directed cases, random traffic.
module tb_wb_seg_q;

  localparam int DEPTH = 2;
`ifdef WB_SEG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sel_lmd = 1'b0;
  logic        in_wr_en = 1'b0;
  logic [4:0]  in_wr_addr = '0;
  logic [31:0] in_lmd = '0;
  logic [31:0] in_aluo = '0;
  logic        in_cond = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic        wb_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        cond;
  logic [31:0] retired_cnt;
  logic [4:0]  fwd_addr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  wb_seg_q #(.DATA_W(32), .REG_AW(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel_lmd(in_sel_lmd),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_lmd(in_lmd),
    .in_aluo(in_aluo), .in_cond(in_cond),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_write(wb_write),
    .wb_addr(wb_addr), .wb_data(wb_data), .cond(cond),
    .retired_cnt(retired_cnt),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        wen;
    logic [4:0]  addr;
    logic        cnd;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_retired = '0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a plain FIFO of resolved entries updated at each edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_retired = '0;
    end else begin
      bit do_push;
      bit do_pop;
      ent_t e;
      do_push = in_valid && (mq.size() != DEPTH);
      do_pop  = (mq.size() != 0) && wb_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (do_pop) begin
          void'(mq.pop_front());
          m_retired = m_retired + 32'd1;
        end
        if (do_push) begin
          e.data = in_sel_lmd ? in_lmd : in_aluo;
          e.wen  = in_wr_en;
          e.addr = in_wr_addr;
          e.cnd  = in_cond;
          mq.push_back(e);
        end
      end
    end
  end

  task automatic check_all();
    logic [31:0] e_data = '0;
    logic [4:0]  e_addr = '0;
    logic        e_cond = 1'b0;
    logic        e_wr = 1'b0;
    logic        e_hit = 1'b0;
    logic [31:0] e_fd = '0;
    if (mq.size() > 0) begin
      e_data = mq[0].data;
      e_addr = mq[0].addr;
      e_cond = mq[0].cnd;
      e_wr   = mq[0].wen && (mq[0].addr != 5'd0);
    end
    if (FWD) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!e_hit && mq[i].wen && mq[i].addr != 5'd0 && mq[i].addr == fwd_addr) begin
          e_hit = 1'b1;
          e_fd  = mq[i].data;
        end
      end
    end
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() != DEPTH});
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, mq.size() != 0});
    chk("wb_write", {31'd0, wb_write}, {31'd0, e_wr});
    chk("wb_addr", {27'd0, wb_addr}, {27'd0, e_addr});
    chk("wb_data", wb_data, e_data);
    chk("cond", {31'd0, cond}, {31'd0, e_cond});
    chk("retired_cnt", retired_cnt, m_retired);
    chk("fwd_hit", {31'd0, fwd_hit}, {31'd0, e_hit});
    chk("fwd_data", fwd_data, e_fd);
  endtask

  always @(negedge clk) if (chk_en) check_all();

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic sel, input logic wen,
                        input logic [4:0] a, input logic [31:0] lmd,
                        input logic [31:0] alu, input logic c);
    in_valid = v; in_sel_lmd = sel; in_wr_en = wen; in_wr_addr = a;
    in_lmd = lmd; in_aluo = alu; in_cond = c;
  endtask

  initial begin
    #1 rst = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    cycle();
    cycle();
    rst = 1'b1;

    // Single entry: written one cycle after the push.
    set_in(1, 0, 1, 5'd8, 32'h0, 32'h1234, 1);
    wb_ready = 1'b1;
    cycle();
    set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    chk("t1_write", {31'd0, wb_write}, 32'd1);
    chk("t1_addr", {27'd0, wb_addr}, 32'd8);
    chk("t1_data", wb_data, 32'h1234);
    chk("t1_cond", {31'd0, cond}, 32'd1);
    cycle();
    chk("t1_empty", {31'd0, wb_valid}, 32'd0);
    chk("t1_retired", retired_cnt, 32'd1);

    // Fill with wb_ready low, third push held off, then drain in order.
    wb_ready = 1'b0;
    set_in(1, 0, 1, 5'd1, 32'h0, 32'h101, 0);
    cycle();
    chk("t2_ready1", {31'd0, in_ready}, 32'd1);
    set_in(1, 0, 1, 5'd2, 32'h0, 32'h102, 0);
    cycle();
    chk("t2_full", {31'd0, in_ready}, 32'd0);
    set_in(1, 0, 1, 5'd3, 32'h0, 32'h103, 1);
    cycle();
    chk("t2_hold", wb_data, 32'h101);
    wb_ready = 1'b1;
    cycle();
    chk("t2_head2", wb_data, 32'h102);
    cycle();
    set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    chk("t2_head3", wb_data, 32'h103);
    cycle();
    chk("t2_retired", retired_cnt, 32'd4);

    // Write to $0 occupies a slot but never strobes.
    wb_ready = 1'b0;
    set_in(1, 1, 1, 5'd0, 32'hDEAD, 32'h5555, 0);
    cycle();
    set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    chk("t3_valid", {31'd0, wb_valid}, 32'd1);
    chk("t3_write", {31'd0, wb_write}, 32'd0);
    chk("t3_data", wb_data, 32'hDEAD);
    wb_ready = 1'b1;
    cycle();
    chk("t3_retired", retired_cnt, 32'd5);

    // Flush overrides simultaneous push and pop.
    wb_ready = 1'b0;
    set_in(1, 0, 1, 5'd4, 32'h0, 32'h44, 0);
    cycle();
    cycle();
    flush = 1'b1;
    wb_ready = 1'b1;
    cycle();
    flush = 1'b0;
    set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    chk("t4_valid", {31'd0, wb_valid}, 32'd0);
    chk("t4_ready", {31'd0, in_ready}, 32'd1);
    chk("t4_retired", retired_cnt, 32'd5);

    // Forwarding: newest of two queued writes to r5 wins.
    wb_ready = 1'b0;
    set_in(1, 0, 1, 5'd5, 32'h0, 32'h11, 0);
    cycle();
    set_in(1, 1, 1, 5'd5, 32'h22, 32'h0, 0);
    cycle();
    set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    fwd_addr = 5'd5;
    #1;
    chk("t5_hit", {31'd0, fwd_hit}, FWD ? 32'd1 : 32'd0);
    chk("t5_data", fwd_data, FWD ? 32'h22 : 32'h0);
    fwd_addr = 5'd0;
    #1;
    chk("t5_hit0", {31'd0, fwd_hit}, 32'd0);

    // Asynchronous reset mid-cycle with two entries queued.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_valid", {31'd0, wb_valid}, 32'd0);
    chk("t6_write", {31'd0, wb_write}, 32'd0);
    chk("t6_retired", retired_cnt, 32'd0);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    cycle();
    rst = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)),
             $urandom, $urandom, 1'($urandom_range(0, 1)));
      wb_ready = $urandom_range(0, 2) != 0;
      flush    = $urandom_range(0, 31) == 0;
      fwd_addr = 5'($urandom_range(0, 7));
      cycle();
    end
    flush = 1'b0;
    set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    cycle();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
